// File: rtl/led_breather.sv
// led_breather: PWM "breathing" driver for the popout LED.
// The duty value ramps up, holds bright, ramps down, holds dark, and repeats.
// Duty and hold counters advance only on tick strobes from the tick divider.
// The optional perceptual gamma stage is enabled by defining LED_BREATHER_GAMMA_EN.
// That stage squares the duty value and adds one clock of duty->led latency.
module led_breather #(
    parameter int PWM_BITS   = 8,
    parameter int STEP       = 8,
    parameter int HOLD_TICKS = 4
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                tick,
    input  logic                enable,
    output logic                led,
    output logic [PWM_BITS-1:0] duty,
    output logic                cycle_done
);

    localparam int HOLD_W = (HOLD_TICKS > 1) ? $clog2(HOLD_TICKS) : 1;
    localparam logic [PWM_BITS-1:0] MAX       = '1;
    localparam logic [PWM_BITS:0]   STEP_W    = (PWM_BITS+1)'(STEP);
    localparam logic [PWM_BITS-1:0] STEP_N    = PWM_BITS'(STEP);
    localparam logic [HOLD_W-1:0]   HOLD_LAST = HOLD_W'(HOLD_TICKS - 1);

    typedef enum logic [2:0] {
        IDLE,
        RAMP_UP,
        HOLD_HIGH,
        RAMP_DOWN,
        HOLD_LOW
    } state_t;

    state_t              state_q, state_d;
    logic [PWM_BITS-1:0] duty_q, duty_d;
    logic [PWM_BITS-1:0] pwm_cnt_q, pwm_cnt_d;
    logic [HOLD_W-1:0]   hold_cnt_q, hold_cnt_d;
    logic                led_q, led_d;
    logic                cycle_done_q, cycle_done_d;
    logic [PWM_BITS:0]   duty_sum;
    logic [PWM_BITS-1:0] duty_eff;

    // Breathing sequencer: decides the next state, duty and hold count.
    always_comb begin
        state_d      = state_q;
        duty_d       = duty_q;
        hold_cnt_d   = hold_cnt_q;
        cycle_done_d = 1'b0;
        duty_sum     = {1'b0, duty_q} + STEP_W;

        if (!enable) begin
            state_d    = IDLE;
            duty_d     = '0;
            hold_cnt_d = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    duty_d  = '0;
                    state_d = RAMP_UP;
                end
                RAMP_UP: begin
                    if (tick) begin
                        if (duty_sum >= {1'b0, MAX}) begin
                            duty_d     = MAX;
                            hold_cnt_d = '0;
                            state_d    = HOLD_HIGH;
                        end else begin
                            duty_d = duty_sum[PWM_BITS-1:0];
                        end
                    end
                end
                HOLD_HIGH: begin
                    if (tick) begin
                        if (hold_cnt_q == HOLD_LAST) begin
                            hold_cnt_d = '0;
                            state_d    = RAMP_DOWN;
                        end else begin
                            hold_cnt_d = hold_cnt_q + HOLD_W'(1);
                        end
                    end
                end
                RAMP_DOWN: begin
                    if (tick) begin
                        if ({1'b0, duty_q} <= STEP_W) begin
                            duty_d     = '0;
                            hold_cnt_d = '0;
                            state_d    = HOLD_LOW;
                        end else begin
                            duty_d = duty_q - STEP_N;
                        end
                    end
                end
                HOLD_LOW: begin
                    if (tick) begin
                        if (hold_cnt_q == HOLD_LAST) begin
                            hold_cnt_d   = '0;
                            cycle_done_d = 1'b1;
                            state_d      = RAMP_UP;
                        end else begin
                            hold_cnt_d = hold_cnt_q + HOLD_W'(1);
                        end
                    end
                end
                default: begin
                    state_d    = IDLE;
                    duty_d     = '0;
                    hold_cnt_d = '0;
                end
            endcase
        end
    end

`ifdef LED_BREATHER_GAMMA_EN
    logic [PWM_BITS-1:0]   duty_eff_q, duty_eff_d;
    logic [2*PWM_BITS-1:0] duty_sq;

    // Gamma curve: square the raw duty and keep the upper half.
    always_comb begin
        duty_sq    = {{PWM_BITS{1'b0}}, duty_q} * {{PWM_BITS{1'b0}}, duty_q};
        duty_eff_d = PWM_BITS'(duty_sq >> PWM_BITS);
    end

    // Pipeline register holding the gamma-corrected duty.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            duty_eff_q <= '0;
        end else begin
            duty_eff_q <= duty_eff_d;
        end
    end

    assign duty_eff = duty_eff_q;
`else
    assign duty_eff = duty_q;
`endif

    // PWM counter and LED compare; enable gates the LED immediately.
    always_comb begin
        pwm_cnt_d = pwm_cnt_q + PWM_BITS'(1);
        led_d     = enable & (pwm_cnt_q < duty_eff);
    end

    // State and output registers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q      <= IDLE;
            duty_q       <= '0;
            pwm_cnt_q    <= '0;
            hold_cnt_q   <= '0;
            led_q        <= 1'b0;
            cycle_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            duty_q       <= duty_d;
            pwm_cnt_q    <= pwm_cnt_d;
            hold_cnt_q   <= hold_cnt_d;
            led_q        <= led_d;
            cycle_done_q <= cycle_done_d;
        end
    end

    assign led        = led_q;
    assign duty       = duty_q;
    assign cycle_done = cycle_done_q;

endmodule
